// File: rtl/arith_sequencer_if.sv
// rtl/arith_sequencer_if.sv - request/result bundle for the arithmetic sequencer
interface arith_sequencer_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [1:0]             op;
    logic [WIDTH-1:0]       in1;
    logic [WIDTH-1:0]       in2;
    logic                   ready;
    logic                   busy;
    logic [2*WIDTH-1:0]     out;
    logic                   flag;
    logic                   err;
    logic                   done;

    modport master (
        output start, op, in1, in2,
        input  ready, busy, out, flag, err, done
    );

    modport slave (
        input  start, op, in1, in2,
        output ready, busy, out, flag, err, done
    );
endinterface

// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - sequences add/sub (one cycle) and shift-add multiply (WIDTH cycles)
// Multiply is compiled in only when ARITH_SEQ_MUL_EN is defined; otherwise op=10 reports err.
module arith_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    arith_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   out_q;
    logic                 flag_q, err_q;

    logic                 ready_o, busy_o, done_o;
    logic                 accept;
    logic                 is_mul;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH-1:0]     diff_w;
    logic [2*WIDTH-1:0]   exec_out;
    logic                 exec_flag, exec_err;

    assign accept = bus.start && ready_o;

`ifdef ARITH_SEQ_MUL_EN
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 mul_last;

    assign is_mul   = (bus.op == 2'b10);
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    // Partial product for the current multiplier bit, shifted into place.
    always_comb begin
        acc_d = acc_q;
        if (b_q[cnt_q[CNT_W-2:0]]) begin
            acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        sum_w     = {1'b0, a_q} + {1'b0, b_q};
        diff_w    = a_q - b_q;
        exec_out  = '0;
        exec_flag = 1'b0;
        exec_err  = 1'b0;
        case (op_q)
            2'b00: begin
                exec_out  = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
                exec_flag = sum_w[WIDTH];
            end
            2'b01: begin
                exec_out  = {{WIDTH{1'b0}}, diff_w};
                exec_flag = (a_q < b_q);
            end
            // Reserved, and multiply when the multiplier is not built.
            default: exec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: state_d = S_DONE;
`ifdef ARITH_SEQ_MUL_EN
            S_MUL: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
`else
            S_MUL:  state_d = S_IDLE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == S_IDLE);
        busy_o  = (state_q == S_EXEC) || (state_q == S_MUL);
        done_o  = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 2'b00;
            a_q    <= '0;
            b_q    <= '0;
            out_q  <= '0;
            flag_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef ARITH_SEQ_MUL_EN
            acc_q  <= '0;
            cnt_q  <= '0;
`endif
        end else begin
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.in1;
                b_q  <= bus.in2;
`ifdef ARITH_SEQ_MUL_EN
                acc_q <= '0;
                cnt_q <= '0;
`endif
            end
            if (state_q == S_EXEC) begin
                out_q  <= exec_out;
                flag_q <= exec_flag;
                err_q  <= exec_err;
            end
`ifdef ARITH_SEQ_MUL_EN
            if (state_q == S_MUL) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CNT_W'(1);
                if (mul_last) begin
                    out_q  <= acc_d;
                    flag_q <= 1'b0;
                    err_q  <= 1'b0;
                end
            end
`endif
        end
    end

    assign bus.ready = ready_o;
    assign bus.busy  = busy_o;
    assign bus.done  = done_o;
    assign bus.out   = out_q;
    assign bus.flag  = flag_q;
    assign bus.err   = err_q;
endmodule
